// File: rtl/g2b_sync_if.sv
// Port bundle for g2b_sync: Gray input and clear from the source side, synchronized
// binary value and its change/step status back to the consumer.
interface g2b_sync_if #(
  parameter int width = 4
);
  logic [width-1:0] g_in;
  logic             err_clr;
  logic [width-1:0] b_out;
  logic             b_valid;
  logic             changed;
  logic [width-1:0] delta;
  logic             step_err;

  modport master (
    output g_in,
    output err_clr,
    input  b_out,
    input  b_valid,
    input  changed,
    input  delta,
    input  step_err
  );

  modport slave (
    input  g_in,
    input  err_clr,
    output b_out,
    output b_valid,
    output changed,
    output delta,
    output step_err
  );
endinterface

// File: rtl/g2b_sync.sv
// Synchronizes an asynchronous Gray-coded value into clk, converts it to binary and
// reports per-sample change, modular forward distance and multi-bit step errors.
module g2b_sync #(
  parameter int width       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  g2b_sync_if.slave  bus
);

  localparam int             CW        = $clog2(SYNC_STAGES + 2);
  localparam logic [CW-1:0]  WARM_LAST = CW'(SYNC_STAGES);

  function automatic logic [width-1:0] gray2bin(input logic [width-1:0] g);
    logic [width-1:0] b;
    b[width-1] = g[width-1];
    for (int i = width - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic int unsigned popcount(input logic [width-1:0] v);
    int unsigned n;
    n = 32'd0;
    for (int i = 0; i < width; i++) begin
      n = n + {31'd0, v[i]};
    end
    return n;
  endfunction

  logic [width-1:0] sync_r [SYNC_STAGES];
  logic [width-1:0] prev_gs_r;
  logic [width-1:0] b_out_r;
  logic [width-1:0] delta_r;
  logic             changed_r;
  logic             step_err_r;
  logic             valid_r;
  logic [CW-1:0]    cnt_r;

  logic [width-1:0] gs_s;
  logic [width-1:0] bin_s;
  logic             multi_s;
  logic [width-1:0] delta_nxt_s;
  logic             changed_nxt_s;
  logic             step_err_nxt_s;
  logic             valid_nxt_s;
  logic [CW-1:0]    cnt_nxt_s;

  // State register: synchronizer chain, output registers and warm-up counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_r[i] <= {width{1'b0}};
      end
      prev_gs_r  <= {width{1'b0}};
      b_out_r    <= {width{1'b0}};
      delta_r    <= {width{1'b0}};
      changed_r  <= 1'b0;
      step_err_r <= 1'b0;
      valid_r    <= 1'b0;
      cnt_r      <= {CW{1'b0}};
    end else begin
      sync_r[0] <= bus.g_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
      prev_gs_r  <= gs_s;
      b_out_r    <= bin_s;
      delta_r    <= delta_nxt_s;
      changed_r  <= changed_nxt_s;
      step_err_r <= step_err_nxt_s;
      valid_r    <= valid_nxt_s;
      cnt_r      <= cnt_nxt_s;
    end
  end

  // Next-state: conversion, change/distance, sticky step error (set beats clear), warm-up.
  always_comb begin
    gs_s           = sync_r[SYNC_STAGES-1];
    bin_s          = gray2bin(gs_s);
    multi_s        = (popcount(gs_s ^ prev_gs_r) > 32'd1);
    delta_nxt_s    = {width{1'b0}};
    changed_nxt_s  = 1'b0;
    step_err_nxt_s = step_err_r;
    valid_nxt_s    = valid_r;
    cnt_nxt_s      = cnt_r;

    if (valid_r && (bin_s != b_out_r)) begin
      changed_nxt_s = 1'b1;
      delta_nxt_s   = bin_s - b_out_r;
    end else begin
      changed_nxt_s = 1'b0;
      delta_nxt_s   = {width{1'b0}};
    end

    if (valid_r && multi_s) begin
      step_err_nxt_s = 1'b1;
    end else if (bus.err_clr) begin
      step_err_nxt_s = 1'b0;
    end else begin
      step_err_nxt_s = step_err_r;
    end

    // The counter saturates on the edge that raises b_valid.
    if (cnt_r == WARM_LAST) begin
      cnt_nxt_s   = cnt_r;
      valid_nxt_s = 1'b1;
    end else begin
      cnt_nxt_s   = cnt_r + CW'(1);
      valid_nxt_s = 1'b0;
    end
  end

  // Output drive: every port comes straight from a register.
  always_comb begin
    bus.b_out    = b_out_r;
    bus.b_valid  = valid_r;
    bus.changed  = changed_r;
    bus.delta    = delta_r;
    bus.step_err = step_err_r;
  end

endmodule

// File: doc/g2b_sync.md
Name: g2b_sync

Overview:
- Destination-side consumer of a Gray-coded value, typically a counter or FIFO pointer generated in another clock domain.
- Passes the asynchronous Gray input through a multi-flop synchronizer, converts it to binary, and registers the result.
- Reports per-sample change, the modular forward distance since the previous sample, and a sticky error when consecutive samples differ in more than one Gray bit.
- Sits directly downstream of the b2g binary-to-Gray converter across the clock-domain boundary.

Parameters:
- width, 4, bit width of Gray input and binary output (>=2).
- SYNC_STAGES, 2, synchronizer flop count (>=2).

Ports:
- clk  input  1  destination-domain clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- g_in  input  width  Gray code from the source domain; asynchronous to clk; at most one bit changes per source update.
- err_clr  input  1  clears step_err (synchronous).
- b_out  output  width  registered binary equivalent of the synchronized g_in.
- b_valid  output  1  high once warm-up after reset completes.
- changed  output  1  one-cycle pulse when b_out takes a new value (only while b_valid).
- delta  output  width  (new b_out - previous b_out) mod 2^width, registered with b_out.
- step_err  output  1  sticky: consecutive synchronized samples differed in >1 bit.

Behaviour:
- Reset (rst high at a rising edge): every synchronizer stage, b_out, delta, changed, step_err, b_valid and the warm-up counter go to 0 at that edge. A mid-operation reset behaves the same and restarts warm-up.
- Synchronizer: g_in → stage[0] → … → stage[SYNC_STAGES-1] (gs). No logic between stages.
- Conversion (combinational on gs):
  - b[width-1] = gs[width-1]
  - b[i] = b[i+1] ^ gs[i] for i = width-2 down to 0.
- Output register:
  - Every edge with rst low: b_out <= b(gs); prev_gs <= gs.
  - Latency from a stable g_in change to b_out is SYNC_STAGES+1 edges (3 with defaults).
- Warm-up:
  - A counter counts edges with rst low, saturating.
  - b_valid goes high at the (SYNC_STAGES+1)th such edge and stays high until the next reset.
  - While b_valid is low: changed=0, delta=0, and step_err is not set. b_out still tracks the input.
- changed and delta (registered, qualified by b_valid):
  - When b(gs) != b_out: changed <= 1 and delta <= b(gs) - b_out, truncated to width (modular).
  - Otherwise: changed <= 0 and delta <= 0.
  - Wrap-around: b_out 2^width-1 → 0 gives delta = 1.
- Step error:
  - Hamming distance hd = popcount(gs ^ prev_gs).
  - If b_valid and hd > 1: step_err <= 1.
  - Else if err_clr: step_err <= 0.
  - A new error and err_clr in the same cycle leave step_err = 1 (set wins).
  - step_err does not stop b_out or delta from updating.
- Source stepping faster than synchronization: only the sampled values are compared. Skipped codes appear as delta > 1 and, if more than one bit differs, as step_err. This is not otherwise flagged.
- Legal decrement (a single-bit Gray change that lowers the count) gives delta = 2^width-1. It is not an error.

Test Plan (width=4, SYNC_STAGES=2):
1. Reset, then release with g_in=0000 → b_out=0, changed=0, delta=0, step_err=0 during reset; b_valid=0 for the first 2 edges after release and 1 from the 3rd edge on.
2. After warm-up, apply the Gray sweep 0000,0001,0011,0010,0110,…,1000, each code held 4 cycles → b_out counts 0..15; each new b_out appears 3 edges after its g_in change; exactly one changed pulse per step with delta=1; step_err stays 0.
3. From g_in=1000 (b_out=15) apply 0000 → b_out=0, changed pulses once, delta=1, step_err=0.
4. From g_in=0001 (b_out=1) apply 0010 (two-bit change) → b_out=3, delta=2, step_err=1 and stays high while g_in holds; a single err_clr pulse clears it; a repeat with err_clr held across the error edge leaves step_err=1.
5. Hold g_in=0110 (b_out=4) for 20 cycles → b_out=4 throughout, changed=0, delta=0; then apply 0010 → b_out=3, delta=15, step_err=0.
6. Mid-sweep at b_out=9 (g_in=1101), assert rst for 1 cycle with step_err=1 → all outputs 0 on the reset edge; after release b_valid is 0 for 2 edges, then b_out=9 with no changed pulse and no step_err during warm-up.
